// File: rtl/pcie_msi_irq_ctrl_if.sv
// Bundle of the PCIe hard IP cfg_interrupt_msi_* signals served by pcie_msi_irq_ctrl.
// master: the interrupt controller side; slave: the hard IP side.
interface pcie_msi_irq_ctrl_if;
    logic [3:0]  cfg_interrupt_msi_enable;
    logic [11:0] cfg_interrupt_msi_mmenable;
    logic        cfg_interrupt_msi_mask_update;
    logic [31:0] cfg_interrupt_msi_data;
    logic [3:0]  cfg_interrupt_msi_select;
    logic [31:0] cfg_interrupt_msi_int;
    logic [31:0] cfg_interrupt_msi_pending_status;
    logic        cfg_interrupt_msi_pending_status_data_enable;
    logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
    logic        cfg_interrupt_msi_sent;
    logic        cfg_interrupt_msi_fail;
    logic [2:0]  cfg_interrupt_msi_attr;
    logic        cfg_interrupt_msi_tph_present;
    logic [1:0]  cfg_interrupt_msi_tph_type;
    logic [8:0]  cfg_interrupt_msi_tph_st_tag;
    logic [3:0]  cfg_interrupt_msi_function_number;

    modport master (
        input  cfg_interrupt_msi_enable,
        input  cfg_interrupt_msi_mmenable,
        input  cfg_interrupt_msi_mask_update,
        input  cfg_interrupt_msi_data,
        input  cfg_interrupt_msi_sent,
        input  cfg_interrupt_msi_fail,
        output cfg_interrupt_msi_select,
        output cfg_interrupt_msi_int,
        output cfg_interrupt_msi_pending_status,
        output cfg_interrupt_msi_pending_status_data_enable,
        output cfg_interrupt_msi_pending_status_function_num,
        output cfg_interrupt_msi_attr,
        output cfg_interrupt_msi_tph_present,
        output cfg_interrupt_msi_tph_type,
        output cfg_interrupt_msi_tph_st_tag,
        output cfg_interrupt_msi_function_number
    );

    modport slave (
        output cfg_interrupt_msi_enable,
        output cfg_interrupt_msi_mmenable,
        output cfg_interrupt_msi_mask_update,
        output cfg_interrupt_msi_data,
        output cfg_interrupt_msi_sent,
        output cfg_interrupt_msi_fail,
        input  cfg_interrupt_msi_select,
        input  cfg_interrupt_msi_int,
        input  cfg_interrupt_msi_pending_status,
        input  cfg_interrupt_msi_pending_status_data_enable,
        input  cfg_interrupt_msi_pending_status_function_num,
        input  cfg_interrupt_msi_attr,
        input  cfg_interrupt_msi_tph_present,
        input  cfg_interrupt_msi_tph_type,
        input  cfg_interrupt_msi_tph_st_tag,
        input  cfg_interrupt_msi_function_number
    );
endinterface

// File: rtl/pcie_msi_irq_ctrl.sv
// Multi-vector MSI request controller: latches per-vector requests, arbitrates round-robin,
// pulses the hard IP and retries after a backoff on fail. PCIE_MSI_IRQ_STATS_EN adds sent/fail counters.
module pcie_msi_irq_ctrl #(
    parameter int MSI_COUNT   = 32,
    parameter int FUNC_NUM    = 0,
    parameter int RETRY_DELAY = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MSI_COUNT-1:0] irq,
    pcie_msi_irq_ctrl_if.master  msi_if
`ifdef PCIE_MSI_IRQ_STATS_EN
    ,
    output logic [31:0]          stat_sent_count,
    output logic [31:0]          stat_fail_count
`endif
);

    localparam int          BO_W     = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY + 1) : 1;
    localparam logic [31:0] VEC_MASK = (MSI_COUNT >= 32) ? 32'hFFFF_FFFF
                                                         : 32'((64'd1 << MSI_COUNT) - 64'd1);
    localparam logic [4:0]  LAST_IDX = 5'(MSI_COUNT - 1);
    localparam logic [5:0]  COUNT6   = 6'(MSI_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_BACKOFF = 2'd2
    } state_t;

    function automatic logic [31:0] alloc_mask(input logic [2:0] mme);
        case (mme)
            3'd0:    alloc_mask = 32'h0000_0001;
            3'd1:    alloc_mask = 32'h0000_0003;
            3'd2:    alloc_mask = 32'h0000_000F;
            3'd3:    alloc_mask = 32'h0000_00FF;
            3'd4:    alloc_mask = 32'h0000_FFFF;
            default: alloc_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        onehot = 32'd1 << idx;
    endfunction

    state_t            r_state;
    logic [31:0]       r_pending;
    logic [31:0]       r_mask;
    logic [31:0]       r_int;
    logic              r_de;
    logic [4:0]        r_rr;
    logic [4:0]        r_sel;
    logic [BO_W-1:0]   r_backoff;

    logic [31:0]       w_irq;
    logic [31:0]       w_alloc;
    logic [31:0]       w_elig;
    logic [31:0]       w_clr;
    logic [31:0]       w_pend_nxt;
    logic [2:0]        w_mme;
    logic              w_en;
    logic              w_sent_ok;
    logic              w_fail;
    logic              w_found;
    logic [4:0]        w_pick;
    logic [5:0]        w_sum;
    logic              w_unused_ok;

    assign w_irq      = 32'(irq);
    assign w_mme      = msi_if.cfg_interrupt_msi_mmenable[FUNC_NUM*3 +: 3];
    assign w_en       = msi_if.cfg_interrupt_msi_enable[FUNC_NUM];
    assign w_alloc    = alloc_mask(w_mme);
    assign w_elig     = r_pending & ~r_mask & w_alloc & VEC_MASK;
    // fail wins when the IP reports both in the same cycle
    assign w_fail     = (r_state == S_WAIT) && msi_if.cfg_interrupt_msi_fail;
    assign w_sent_ok  = (r_state == S_WAIT) && msi_if.cfg_interrupt_msi_sent
                        && !msi_if.cfg_interrupt_msi_fail;
    assign w_clr      = w_sent_ok ? onehot(r_sel) : 32'd0;
    assign w_pend_nxt = ((r_pending & ~w_clr) | w_irq) & VEC_MASK;
    assign w_unused_ok = ^{msi_if.cfg_interrupt_msi_enable, msi_if.cfg_interrupt_msi_mmenable};

    // Search starts at the round-robin pointer and wraps at MSI_COUNT
    always_comb begin
        w_found = 1'b0;
        w_pick  = 5'd0;
        w_sum   = 6'd0;
        for (int k = 0; k < MSI_COUNT; k++) begin
            w_sum = {1'b0, r_rr} + 6'(k);
            if (w_sum >= COUNT6) begin
                w_sum = w_sum - COUNT6;
            end
            if (!w_found && w_elig[w_sum[4:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[4:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
            r_mask    <= 32'd0;
            r_de      <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_de      <= (w_pend_nxt != r_pending);
            if (msi_if.cfg_interrupt_msi_mask_update) begin
                r_mask <= msi_if.cfg_interrupt_msi_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_int     <= 32'd0;
            r_rr      <= 5'd0;
            r_sel     <= 5'd0;
            r_backoff <= '0;
        end else begin
            r_int <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_en && w_found) begin
                        r_sel   <= w_pick;
                        r_int   <= onehot(w_pick);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_fail) begin
                        r_backoff <= BO_W'(RETRY_DELAY);
                        r_state   <= S_BACKOFF;
                    end else if (w_sent_ok) begin
                        r_rr    <= (r_sel == LAST_IDX) ? 5'd0 : r_sel + 5'd1;
                        r_state <= S_IDLE;
                    end
                end
                S_BACKOFF: begin
                    r_backoff <= r_backoff - BO_W'(1);
                    if (r_backoff <= BO_W'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PCIE_MSI_IRQ_STATS_EN
    logic [31:0] r_sent_cnt;
    logic [31:0] r_fail_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent_cnt <= 32'd0;
            r_fail_cnt <= 32'd0;
        end else begin
            if (w_sent_ok && (r_sent_cnt != 32'hFFFF_FFFF)) begin
                r_sent_cnt <= r_sent_cnt + 32'd1;
            end
            if (w_fail && (r_fail_cnt != 32'hFFFF_FFFF)) begin
                r_fail_cnt <= r_fail_cnt + 32'd1;
            end
        end
    end

    assign stat_sent_count = r_sent_cnt;
    assign stat_fail_count = r_fail_cnt;
`endif

    assign msi_if.cfg_interrupt_msi_int                         = r_int;
    assign msi_if.cfg_interrupt_msi_pending_status              = r_pending;
    assign msi_if.cfg_interrupt_msi_pending_status_data_enable  = r_de;
    assign msi_if.cfg_interrupt_msi_select                      = 4'(FUNC_NUM);
    assign msi_if.cfg_interrupt_msi_pending_status_function_num = 4'(FUNC_NUM);
    assign msi_if.cfg_interrupt_msi_function_number             = 4'(FUNC_NUM);
    assign msi_if.cfg_interrupt_msi_attr                        = 3'd0;
    assign msi_if.cfg_interrupt_msi_tph_present                 = 1'b0;
    assign msi_if.cfg_interrupt_msi_tph_type                    = 2'd0;
    assign msi_if.cfg_interrupt_msi_tph_st_tag                  = 9'd0;

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Directed bench for pcie_msi_irq_ctrl with a cycle-stamped scoreboard of expected MSI pulses.
module tb_pcie_msi_irq_ctrl;

    localparam int MSI_COUNT   = 32;
    localparam int FUNC_NUM    = 0;
    localparam int RETRY_DELAY = 16;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          exp_sent = 0;
    int          exp_fail = 0;
    exp_t        exp_q[$];

    pcie_msi_irq_ctrl_if u_if ();

`ifdef PCIE_MSI_IRQ_STATS_EN
    logic [31:0] stat_sent_count;
    logic [31:0] stat_fail_count;
`endif

    pcie_msi_irq_ctrl #(
        .MSI_COUNT  (MSI_COUNT),
        .FUNC_NUM   (FUNC_NUM),
        .RETRY_DELAY(RETRY_DELAY)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .msi_if         (u_if)
`ifdef PCIE_MSI_IRQ_STATS_EN
        ,
        .stat_sent_count(stat_sent_count),
        .stat_fail_count(stat_fail_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every cycle msi_int is either the scoreboard head due now, or zero
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("msi_int", u_if.cfg_interrupt_msi_int, e.val);
        end else begin
            chk("msi_int_quiet", u_if.cfg_interrupt_msi_int, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_issue(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL issue_timeout: observed %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send();
        u_if.cfg_interrupt_msi_sent = 1'b1;
        tick();
        u_if.cfg_interrupt_msi_sent = 1'b0;
        exp_sent++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef PCIE_MSI_IRQ_STATS_EN
        chk({tag, "_sent_cnt"}, stat_sent_count, 32'(exp_sent));
        chk({tag, "_fail_cnt"}, stat_fail_count, 32'(exp_fail));
`else
        chk({tag, "_no_stats"}, u_if.cfg_interrupt_msi_attr, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        irq = 32'd0;
        u_if.cfg_interrupt_msi_enable      = 4'h1;
        u_if.cfg_interrupt_msi_mmenable    = 12'h005;
        u_if.cfg_interrupt_msi_mask_update = 1'b0;
        u_if.cfg_interrupt_msi_data        = 32'd0;
        u_if.cfg_interrupt_msi_sent        = 1'b0;
        u_if.cfg_interrupt_msi_fail        = 1'b0;
        repeat (3) tick();

        chk("rst_pending", u_if.cfg_interrupt_msi_pending_status, 32'd0);
        chk("rst_de", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        chk("select", 32'(u_if.cfg_interrupt_msi_select), 32'(FUNC_NUM));
        chk("fn_num", 32'(u_if.cfg_interrupt_msi_function_number), 32'(FUNC_NUM));
        chk("ps_fn_num", 32'(u_if.cfg_interrupt_msi_pending_status_function_num), 32'(FUNC_NUM));
        chk("attr_tph", 32'({u_if.cfg_interrupt_msi_attr, u_if.cfg_interrupt_msi_tph_present,
                             u_if.cfg_interrupt_msi_tph_type, u_if.cfg_interrupt_msi_tph_st_tag}), 32'd0);
        chk_stats("rst");
        rst = 1'b0;
        tick();

        // Round robin: 0x11 -> vec0 then vec4; then 0x21 with rr=5 -> vec5 first
        irq = 32'h11; push(32'h01, cyc + 2); tick(); irq = 32'd0;
        wait_issue(8); push(32'h10, cyc + 2); send();
        wait_issue(8); send();
        irq = 32'h21; push(32'h20, cyc + 2); tick(); irq = 32'd0;
        wait_issue(8); push(32'h01, cyc + 2); send();
        wait_issue(8); send();
        tick();
        chk("rr_all_clear", u_if.cfg_interrupt_msi_pending_status, 32'd0);

        // Single vector pulse, pending status and data_enable strobes
        irq = 32'h8; push(32'h8, cyc + 2); tick(); irq = 32'd0;
        chk("t1_pend_set", u_if.cfg_interrupt_msi_pending_status, 32'h8);
        chk("t1_de_rise", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd1);
        tick();
        chk("t1_de_single", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        wait_issue(8);
        chk("t1_pend_held", u_if.cfg_interrupt_msi_pending_status, 32'h8);
        send();
        chk("t1_pend_clr", u_if.cfg_interrupt_msi_pending_status, 32'd0);
        chk("t1_de_clr", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd1);
        tick();
        chk("t1_de_low", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);

        // Masked vector stays pending until unmasked
        u_if.cfg_interrupt_msi_mask_update = 1'b1; u_if.cfg_interrupt_msi_data = 32'h8;
        tick();
        u_if.cfg_interrupt_msi_mask_update = 1'b0; u_if.cfg_interrupt_msi_data = 32'd0;
        irq = 32'h8; tick(); irq = 32'd0;
        repeat (5) tick();
        chk("mask_held", u_if.cfg_interrupt_msi_pending_status, 32'h8);
        u_if.cfg_interrupt_msi_mask_update = 1'b1; push(32'h8, cyc + 2); tick();
        u_if.cfg_interrupt_msi_mask_update = 1'b0;
        wait_issue(8); send();

        // Unallocated vector stays pending until mme grows
        u_if.cfg_interrupt_msi_mmenable = 12'h001;
        irq = 32'h10; tick(); irq = 32'd0;
        repeat (5) tick();
        chk("alloc_held", u_if.cfg_interrupt_msi_pending_status, 32'h10);
        u_if.cfg_interrupt_msi_mmenable = 12'h003; push(32'h10, cyc + 1); tick();
        wait_issue(8); send();
        u_if.cfg_interrupt_msi_mmenable = 12'h005;

        // Fail then retry after backoff
        irq = 32'h4; push(32'h4, cyc + 2); tick(); irq = 32'd0;
        wait_issue(8);
        u_if.cfg_interrupt_msi_fail = 1'b1; push(32'h4, cyc + 18); tick();
        u_if.cfg_interrupt_msi_fail = 1'b0; exp_fail++;
        chk("fail_pend_kept", u_if.cfg_interrupt_msi_pending_status, 32'h4);
        wait_issue(25); send();
        chk_stats("fail1");

        // sent and fail together behave as fail
        irq = 32'h2; push(32'h2, cyc + 2); tick(); irq = 32'd0;
        wait_issue(8);
        u_if.cfg_interrupt_msi_sent = 1'b1; u_if.cfg_interrupt_msi_fail = 1'b1;
        push(32'h2, cyc + 18); tick();
        u_if.cfg_interrupt_msi_sent = 1'b0; u_if.cfg_interrupt_msi_fail = 1'b0; exp_fail++;
        chk("both_pend_kept", u_if.cfg_interrupt_msi_pending_status, 32'h2);
        wait_issue(25); send();
        chk_stats("both");

        // Disabled function accumulates; reset mid-WAIT; late sent ignored
        u_if.cfg_interrupt_msi_enable = 4'h0;
        irq = 32'h1; tick(); irq = 32'd0;
        repeat (4) tick();
        chk("dis_pend", u_if.cfg_interrupt_msi_pending_status, 32'h1);
        u_if.cfg_interrupt_msi_enable = 4'h1; push(32'h1, cyc + 1); tick();
        wait_issue(8);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_sent = 0; exp_fail = 0;
        chk("rst_wait_pend", u_if.cfg_interrupt_msi_pending_status, 32'd0);
        chk("rst_wait_de", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        chk_stats("rst_wait");
        u_if.cfg_interrupt_msi_sent = 1'b1; tick(); u_if.cfg_interrupt_msi_sent = 1'b0;
        tick();
        chk("late_sent_pend", u_if.cfg_interrupt_msi_pending_status, 32'd0);
        chk("late_sent_de", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
        chk_stats("late_sent");
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
